// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide engine for the EX stage. It accepts one
//   M-extension operation, holds IF/ID/EX through muldiv_stall while it
//   computes, and then presents the result until the pipeline takes it.
//
//   Multiply: shift-add, STEP multiplier bits per cycle into a 2*XLEN
//             accumulator (multiplier starts in the low half).
//   Divide:   restoring division, STEP quotient bits per cycle.
//   Signed operations run on magnitudes; signs are fixed up in the FIX state.
//
// Parameters
//   XLEN : operand/result width
//   STEP : bits retired per CALC cycle (1, 2, 4 or 8; XLEN % STEP == 0)
//
// Ports
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   cmd_muldiv_ex  : M-extension op present in EX
//   alu_code_ex    : funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   rs1_sel        : multiplicand / dividend
//   rs2_sel        : multiplier / divisor
//   rd_adr_ex      : destination register of the op
//   stall          : downstream stall, only extends DONE
//   rst_pipe       : synchronous flush, highest priority
//   muldiv_stall   : hold IF/ID/EX (combinational)
//   muldiv_done    : result valid
//   muldiv_result  : result
//   muldiv_rd_adr  : destination register captured with the op
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_muldiv_ex,
    input  logic [2:0]      alu_code_ex,
    input  logic [XLEN-1:0] rs1_sel,
    input  logic [XLEN-1:0] rs2_sel,
    input  logic [4:0]      rd_adr_ex,
    input  logic            stall,
    input  logic            rst_pipe,
    output logic            muldiv_stall,
    output logic            muldiv_done,
    output logic [XLEN-1:0] muldiv_result,
    output logic [4:0]      muldiv_rd_adr
);

    localparam int N     = XLEN / STEP;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [2:0]        op_q,      op_d;
    logic              sign1_q,   sign1_d;
    logic              sign2_q,   sign2_d;
    logic [XLEN-1:0]   mcand_q,   mcand_d;    // |rs1| for multiply
    logic [XLEN-1:0]   divisor_q, divisor_d;  // |rs2| for divide
    logic [2*XLEN-1:0] acc_q,     acc_d;      // product accumulator
    logic [XLEN-1:0]   rem_q,     rem_d;      // partial remainder
    logic [XLEN-1:0]   quo_q,     quo_d;      // dividend shifting out, quotient in
    logic [XLEN-1:0]   result_q,  result_d;
    logic [4:0]        rd_q,      rd_d;

    // ------------------------------------------------------------------
    // Operand decode at acceptance
    // ------------------------------------------------------------------
    logic            a_signed, b_signed;
    logic            s1_in, s2_in;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_by_zero, div_overflow;
    logic [XLEN-1:0] special_res;

    always_comb begin
        a_signed = (alu_code_ex == F_MULH) || (alu_code_ex == F_MULHSU) ||
                   (alu_code_ex == F_DIV)  || (alu_code_ex == F_REM);
        b_signed = (alu_code_ex == F_MULH) || (alu_code_ex == F_DIV) ||
                   (alu_code_ex == F_REM);
        s1_in    = a_signed & rs1_sel[XLEN-1];
        s2_in    = b_signed & rs2_sel[XLEN-1];
        a_mag    = s1_in ? (~rs1_sel + 1'b1) : rs1_sel;
        b_mag    = s2_in ? (~rs2_sel + 1'b1) : rs2_sel;

        div_by_zero  = alu_code_ex[2] && (rs2_sel == '0);
        div_overflow = ((alu_code_ex == F_DIV) || (alu_code_ex == F_REM)) &&
                       (rs1_sel == MOST_NEG) && (rs2_sel == '1);

        // alu_code_ex[1] distinguishes REM* from DIV*
        if (div_by_zero)
            special_res = alu_code_ex[1] ? rs1_sel : '1;
        else
            special_res = alu_code_ex[1] ? '0 : rs1_sel;
    end

    // ------------------------------------------------------------------
    // STEP-deep combinational iteration chains
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] mul_stage [STEP+1];
    logic [XLEN-1:0]   rem_stage [STEP+1];
    logic [XLEN-1:0]   quo_stage [STEP+1];

    assign mul_stage[0] = acc_q;
    assign rem_stage[0] = rem_q;
    assign quo_stage[0] = quo_q;

    genvar gi;
    generate
        for (gi = 0; gi < STEP; gi++) begin : g_step
            logic [XLEN:0] mul_sum;
            logic [XLEN:0] rem_shift;
            logic [XLEN:0] rem_diff;

            // Add the multiplicand into the high half when the current
            // multiplier bit (LSB) is set, then shift the whole thing right.
            assign mul_sum = {1'b0, mul_stage[gi][2*XLEN-1:XLEN]} +
                             (mul_stage[gi][0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
            assign mul_stage[gi+1] = {mul_sum, mul_stage[gi][XLEN-1:1]};

            // Remainder is always below the divisor, so the shifted value
            // fits in XLEN+1 bits and the difference sign is its MSB.
            assign rem_shift = {rem_stage[gi], quo_stage[gi][XLEN-1]};
            assign rem_diff  = rem_shift - {1'b0, divisor_q};
            assign rem_stage[gi+1] = rem_diff[XLEN] ? rem_shift[XLEN-1:0]
                                                    : rem_diff[XLEN-1:0];
            assign quo_stage[gi+1] = {quo_stage[gi][XLEN-2:0], ~rem_diff[XLEN]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sign fix-up and result selection
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_result;

    always_comb begin
        // Sign flags are only ever set for the signed views, so the XOR
        // covers MUL/MULH/MULHSU/MULHU and DIV/DIVU alike.
        prod_fix = (sign1_q ^ sign2_q) ? (~acc_q + 1'b1) : acc_q;
        quo_fix  = (sign1_q ^ sign2_q) ? (~quo_q + 1'b1) : quo_q;
        rem_fix  = sign1_q ? (~rem_q + 1'b1) : rem_q;

        case (op_q)
            F_MUL:          fix_result = prod_fix[XLEN-1:0];
            3'b100, 3'b101: fix_result = quo_fix;
            3'b110, 3'b111: fix_result = rem_fix;
            default:        fix_result = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        sign1_d   = sign1_q;
        sign2_d   = sign2_q;
        mcand_d   = mcand_q;
        divisor_d = divisor_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        result_d  = result_q;
        rd_d      = rd_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_muldiv_ex) begin
                    op_d      = alu_code_ex;
                    rd_d      = rd_adr_ex;
                    sign1_d   = s1_in;
                    sign2_d   = s2_in;
                    mcand_d   = a_mag;
                    divisor_d = b_mag;
                    acc_d     = {{XLEN{1'b0}}, b_mag};
                    rem_d     = '0;
                    quo_d     = a_mag;
                    cnt_d     = '0;
                    if (div_by_zero || div_overflow) begin
                        result_d = special_res;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (op_q[2]) begin
                    rem_d = rem_stage[STEP];
                    quo_d = quo_stage[STEP];
                end else begin
                    acc_d = mul_stage[STEP];
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST)
                    state_d = S_FIX;
            end
            S_FIX: begin
                result_d = fix_result;
                state_d  = S_DONE;
            end
            default: begin  // S_DONE: cmd_muldiv_ex still names this op
                if (!stall)
                    state_d = S_IDLE;
            end
        endcase

        if (rst_pipe) begin
            state_d  = S_IDLE;
            result_d = '0;
            rd_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            mcand_q   <= '0;
            divisor_q <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            result_q  <= '0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            sign1_q   <= sign1_d;
            sign2_q   <= sign2_d;
            mcand_q   <= mcand_d;
            divisor_q <= divisor_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            result_q  <= result_d;
            rd_q      <= rd_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign muldiv_stall  = ((state_q == S_IDLE) && cmd_muldiv_ex) ||
                           (state_q == S_CALC) || (state_q == S_FIX);
    assign muldiv_done   = (state_q == S_DONE);
    assign muldiv_result = result_q;
    assign muldiv_rd_adr = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed test of muldiv_unit with two instances (STEP=1 and STEP=4) that
//   share operands, stall and rst_pipe but have separate cmd inputs.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd1 = 1'b0, cmd4 = 1'b0;
    logic [2:0]  code = 3'b000;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic [4:0]  rd = '0;
    logic        stall = 1'b0, rst_pipe = 1'b0;

    logic        stall_o1, done1, stall_o4, done4;
    logic [31:0] res1, res4;
    logic [4:0]  rda1, rda4;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .STEP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_muldiv_ex(cmd1), .alu_code_ex(code),
        .rs1_sel(rs1), .rs2_sel(rs2), .rd_adr_ex(rd), .stall(stall),
        .rst_pipe(rst_pipe), .muldiv_stall(stall_o1), .muldiv_done(done1),
        .muldiv_result(res1), .muldiv_rd_adr(rda1)
    );

    muldiv_unit #(.XLEN(32), .STEP(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .cmd_muldiv_ex(cmd4), .alu_code_ex(code),
        .rs1_sel(rs1), .rs2_sel(rs2), .rd_adr_ex(rd), .stall(stall),
        .rst_pipe(rst_pipe), .muldiv_stall(stall_o4), .muldiv_done(done4),
        .muldiv_result(res4), .muldiv_rd_adr(rda4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp)
            passed++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Launch one op on both instances (cmd for cycle 0 only) and watch for
    // done; check latency, result, rd and the number of stalled cycles.
    task automatic run_op(input string name, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input logic [31:0] exp,
                          input int lat1, input int lat4);
        int d1, d4, stall_cnt;
        logic [31:0] r1c, r4c;
        logic [4:0]  a1c, a4c;
        d1 = -1; d4 = -1; r1c = '0; r4c = '0; a1c = '0; a4c = '0;
        @(posedge clk); #1;
        code = f3; rs1 = a; rs2 = b; rd = r; cmd1 = 1'b1; cmd4 = 1'b1;
        @(negedge clk);
        chk({name, " stall_c0"}, 64'(stall_o1), 64'(1));
        stall_cnt = stall_o1 ? 1 : 0;
        for (int cyc = 1; cyc <= lat1 + 4; cyc++) begin
            @(posedge clk); #1;
            cmd1 = 1'b0; cmd4 = 1'b0;
            @(negedge clk);
            if (stall_o1) stall_cnt++;
            if (done1 && d1 < 0) begin d1 = cyc; r1c = res1; a1c = rda1; end
            if (done4 && d4 < 0) begin d4 = cyc; r4c = res4; a4c = rda4; end
        end
        chk({name, " lat_s1"},   64'(d1),        64'(lat1));
        chk({name, " res_s1"},   64'(r1c),       64'(exp));
        chk({name, " rd_s1"},    64'(a1c),       64'(r));
        chk({name, " stallcnt"}, 64'(stall_cnt), 64'(lat1));
        chk({name, " lat_s4"},   64'(d4),        64'(lat4));
        chk({name, " res_s4"},   64'(r4c),       64'(exp));
        chk({name, " rd_s4"},    64'(a4c),       64'(r));
        $display("op %-8s a=%08h b=%08h -> s1 %08h @%0d, s4 %08h @%0d (exp %08h)",
                 name, a, b, r1c, d1, r4c, d4, exp);
    endtask

    initial begin
        bit saw;

        // ---------------- reset ----------------
        #12;
        chk("rst done1",  64'(done1),    64'(0));
        chk("rst res1",   64'(res1),     64'(0));
        chk("rst rd1",    64'(rda1),     64'(0));
        chk("rst stall1", 64'(stall_o1), 64'(0));
        chk("rst done4",  64'(done4),    64'(0));
        @(negedge clk); rst_n = 1'b1;

        // ---------------- normal path ----------------
        run_op("MUL",    3'b000, 32'd7,        32'hFFFF_FFF9, 5'd1,  32'hFFFF_FFCF, 34, 10);
        run_op("MULH",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 34, 10);
        run_op("MULHU",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 34, 10);
        run_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'd2,        5'd4,  32'hFFFF_FFFF, 34, 10);
        run_op("MULH2",  3'b001, 32'hFFFF_FFF9, 32'd2,        5'd5,  32'hFFFF_FFFF, 34, 10);
        run_op("DIV",    3'b100, 32'hFFFF_FFF9, 32'd2,        5'd6,  32'hFFFF_FFFD, 34, 10);
        run_op("REM",    3'b110, 32'hFFFF_FFF9, 32'd2,        5'd7,  32'hFFFF_FFFF, 34, 10);
        run_op("DIVU",   3'b101, 32'd100,      32'd7,         5'd8,  32'd14,        34, 10);
        run_op("REMU",   3'b111, 32'd100,      32'd7,         5'd9,  32'd2,         34, 10);
        run_op("DIV2",   3'b100, 32'd7,        32'hFFFF_FFFE, 5'd10, 32'hFFFF_FFFD, 34, 10);
        run_op("REM2",   3'b110, 32'd7,        32'hFFFF_FFFE, 5'd11, 32'd1,         34, 10);

        // ---------------- special cases ----------------
        run_op("DIVU/0", 3'b101, 32'd12345,    32'd0,         5'd12, 32'hFFFF_FFFF, 1, 1);
        run_op("REM/0",  3'b110, 32'd5,        32'd0,         5'd13, 32'd5,         1, 1);
        run_op("DIVOVF", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1, 1);
        run_op("REMOVF", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0,        1, 1);

        // ---------------- rst_pipe in CALC cycle 5 ----------------
        saw = 1'b0;
        @(posedge clk); #1;
        code = 3'b000; rs1 = 32'd3; rs2 = 32'd5; rd = 5'd16; cmd1 = 1'b1; cmd4 = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            cmd1 = 1'b0; cmd4 = 1'b0;
            rst_pipe = (cyc == 5);
            @(negedge clk);
            if (cyc == 6) begin
                chk("rstpipe stall1", 64'(stall_o1), 64'(0));
                chk("rstpipe stall4", 64'(stall_o4), 64'(0));
                chk("rstpipe res1",   64'(res1),     64'(0));
                chk("rstpipe rd1",    64'(rda1),     64'(0));
                chk("rstpipe res4",   64'(res4),     64'(0));
            end
            if (done1 || done4) saw = 1'b1;
        end
        chk("rstpipe nodone", 64'(saw), 64'(0));
        $display("op RSTPIPE aborted, done seen=%0d", saw);
        run_op("MULpost", 3'b000, 32'd3, 32'd5, 5'd17, 32'd15, 34, 10);

        // ---------------- asynchronous reset mid-op ----------------
        saw = 1'b0;
        @(posedge clk); #1;
        code = 3'b101; rs1 = 32'd50; rs2 = 32'd3; rd = 5'd18; cmd1 = 1'b1; cmd4 = 1'b1;
        @(posedge clk); #1;
        cmd1 = 1'b0; cmd4 = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst stall1", 64'(stall_o1), 64'(0));
        chk("arst stall4", 64'(stall_o4), 64'(0));
        chk("arst res1",   64'(res1),     64'(0));
        chk("arst rd4",    64'(rda4),     64'(0));
        @(negedge clk); rst_n = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done1 || done4) saw = 1'b1;
        end
        chk("arst nodone", 64'(saw), 64'(0));
        $display("op ARST aborted, done seen=%0d", saw);

        // ---------------- stall at DONE, cmd ignored in DONE ----------------
        begin
            int d1;
            d1 = -1;
            @(posedge clk); #1;
            code = 3'b011; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF; rd = 5'd19;
            cmd1 = 1'b1; cmd4 = 1'b1;
            for (int cyc = 1; cyc <= 40; cyc++) begin
                @(posedge clk); #1;
                cmd1 = 1'b0;
                cmd4 = (cyc >= 10 && cyc <= 13);
                stall = (cyc >= 10 && cyc <= 12);
                @(negedge clk);
                if (cyc >= 10 && cyc <= 13) begin
                    chk($sformatf("hold done c%0d", cyc),  64'(done4),    64'(1));
                    chk($sformatf("hold res c%0d", cyc),   64'(res4),     64'(32'hFFFF_FFFE));
                    chk($sformatf("hold stall c%0d", cyc), 64'(stall_o4), 64'(0));
                end
                if (cyc == 14) begin
                    chk("hold exit done",  64'(done4),    64'(0));
                    chk("hold exit stall", 64'(stall_o4), 64'(0));
                end
                if (done1 && d1 < 0) d1 = cyc;
            end
            chk("hold s1 lat", 64'(d1), 64'(34));
            $display("op STALLDN held 4 cycles, s1 done @%0d", d1);
        end

        // ---------------- back-to-back MULs on STEP=4 ----------------
        @(posedge clk); #1;
        code = 3'b000; rs1 = 32'd6; rs2 = 32'd7; rd = 5'd3; cmd1 = 1'b1; cmd4 = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            cmd1 = 1'b0;
            cmd4 = (cyc == 11);
            if (cyc == 11) begin
                rs1 = 32'd9; rs2 = 32'd10; rd = 5'd9;
            end
            @(negedge clk);
            if (cyc == 10) begin
                chk("b2b A done", 64'(done4), 64'(1));
                chk("b2b A res",  64'(res4),  64'(42));
                chk("b2b A rd",   64'(rda4),  64'(3));
            end
            if (cyc == 11) begin
                chk("b2b B stall", 64'(stall_o4), 64'(1));
                chk("b2b B nodn",  64'(done4),    64'(0));
            end
            if (cyc == 21) begin
                chk("b2b B done", 64'(done4), 64'(1));
                chk("b2b B res",  64'(res4),  64'(90));
                chk("b2b B rd",   64'(rda4),  64'(9));
            end
            if (cyc == 34) begin
                chk("b2b s1 done", 64'(done1), 64'(1));
                chk("b2b s1 res",  64'(res1),  64'(42));
                chk("b2b s1 rd",   64'(rda1),  64'(3));
            end
        end
        $display("op B2B two MULs retired on s4, res=%08h rd=%0d", res4, rda4);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide engine attached to the execution stage. It is parametrised in data width and in bits retired per cycle. It accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation from EX and holds the pipeline through `muldiv_stall` while it computes. It then presents the result for one or more cycles so the EX→MA register can capture it in place of the ALU result.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width.
- `STEP`, default 1: bits retired per CALC cycle. Legal values are 1, 2, 4 and 8, and `XLEN % STEP == 0`. The iteration count is N = XLEN/STEP.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cmd_muldiv_ex` input 1: an M-extension operation occupies EX.
- `alu_code_ex` input 3: funct3. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_sel` input XLEN: forwarded rs1 (multiplicand or dividend).
- `rs2_sel` input XLEN: forwarded rs2 (multiplier or divisor).
- `rd_adr_ex` input 5: destination register.
- `stall` input 1: downstream pipeline stall.
- `rst_pipe` input 1: synchronous pipeline flush/abort.
- `muldiv_stall` output 1: hold IF/ID/EX.
- `muldiv_done` output 1: result valid.
- `muldiv_result` output XLEN: final result.
- `muldiv_rd_adr` output 5: captured destination register.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - On `cmd_muldiv_ex=1`, latch operands, funct3, `rd_adr_ex` and operand signs.
  - Convert operands to magnitudes. Signed operands: rs1 for MULH/MULHSU/DIV/REM; rs2 for MULH/DIV/REM.
  - Clear the iteration counter and go to CALC.
  - Special cases bypass CALC and go straight to DONE with the result preloaded:
    - Divisor 0: DIV/DIVU return all-ones; REM/REMU return the dividend.
    - DIV of 0x8000_0000 (the most negative value) by −1 returns the dividend; REM of the same returns 0.
- CALC:
  - Multiply: shift-add STEP multiplier bits per cycle into a 2·XLEN accumulator.
  - Divide: restoring division, STEP quotient bits per cycle, using an XLEN+1 bit partial remainder.
  - Counter increments each cycle. At count N−1, go to FIX.
- FIX, one cycle:
  - Multiply: negate the 2·XLEN product if the operand signs differ (signed views only).
  - Divide: quotient is negative if the signs differ; the remainder takes the dividend's sign.
  - Select the low half (MUL), high half (MULH*), quotient or remainder into `muldiv_result`. Go to DONE.
- DONE:
  - `muldiv_done=1`. Hold while `stall=1`. Go to IDLE on the first cycle with `stall=0`.
  - `cmd_muldiv_ex` is ignored in DONE. It still refers to the finishing instruction.
- `muldiv_stall` = (IDLE & `cmd_muldiv_ex`) | CALC | FIX. It is combinational and never high in DONE.
- `rst_pipe` takes priority over everything:
  - State goes to IDLE, and `muldiv_done`, `muldiv_result` and `muldiv_rd_adr` clear to 0 on the next edge.
  - A `cmd_muldiv_ex` present in the same cycle is not accepted.
- `stall` does not freeze CALC/FIX. It only extends DONE.
- Reset values: state IDLE; `muldiv_done`=0, `muldiv_result`=0, `muldiv_rd_adr`=0; `muldiv_stall`=0 once `cmd_muldiv_ex` is low. All internal registers clear to 0.

## Timing
- Cycle 0 is the cycle in which IDLE sees `cmd_muldiv_ex=1`. `muldiv_stall` is high in cycle 0.
- Normal path:
  - Cycles 1..N: CALC.
  - Cycle N+1: FIX.
  - Cycle N+2: DONE, with `muldiv_done=1` and `muldiv_stall=0`.
  - Total latency is N+2. STEP=1 gives 34, STEP=4 gives 10 (XLEN=32).
- Special-case path: DONE in cycle 1, so `muldiv_stall` is high for cycle 0 only.
- Back-to-back operations:
  - The next M-op can be accepted in the cycle after DONE exits.
  - No bubble is required beyond the IDLE acceptance cycle.
- Asynchronous reset in mid-operation aborts immediately. No `muldiv_done` pulse is emitted for the aborted operation.

## Test plan
- MUL, rs1=7, rs2=0xFFFF_FFF9 (−7 as an unsigned 32-bit pattern), STEP=1 → `muldiv_done` in cycle 34, result 0xFFFF_FFCF; `muldiv_stall` high cycles 0..33.
- MULH 0x8000_0000×0x8000_0000 → 0x4000_0000. MULHU 0xFFFF_FFFF×0xFFFF_FFFF → 0xFFFF_FFFE. MULHSU 0xFFFF_FFFF×2 → 0xFFFF_FFFF.
- DIV −7/2 → 0xFFFF_FFFD. REM −7/2 → 0xFFFF_FFFF. DIVU 100/7 → 14. REMU 100/7 → 2. Repeat all with STEP=4 and check done in cycle 10.
- DIVU x/0 → 0xFFFF_FFFF. REM 5/0 → 5. DIV 0x8000_0000/−1 → 0x8000_0000. REM 0x8000_0000/−1 → 0. All of these are done in cycle 1.
- `rst_pipe` asserted in CALC cycle 5 → IDLE on the next edge, `muldiv_stall`=0, no `muldiv_done`, result 0. A new op started afterwards completes correctly.
- `stall` held high for 3 cycles at DONE → `muldiv_done` and the result are held stable for 4 cycles. Two consecutive MULs retire both results with the correct `muldiv_rd_adr`.
